// File: rtl/fmap_out_drain_pkg.sv
// Shared definitions for the feature-map output drain: default
// parameter values and the frame-control state encoding.
package fmap_out_drain_pkg;

    localparam int DEF_DATA_IN_WIDTH  = 512;
    localparam int DEF_DATA_OUT_WIDTH = 64;
    localparam int DEF_FIFO_DEPTH     = 4;
    localparam int DEF_FRAME_WORDS    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } drainState_e;

endpackage

// File: rtl/drain_fifo.sv
// Single-clock word buffer between the layer output and the beat
// serializer. A push into a full buffer is honoured only when a pop
// happens in the same cycle, so the slot being vacated is reused.
module drain_fifo
    import fmap_out_drain_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_IN_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fmap_out_drain.sv
// Drains one frame of wide layer output words to a narrow host stream.
// Words are buffered in drain_fifo and split LSB-first into beats; the
// frame ends when the last beat of the final word is accepted by the sink.
module fmap_out_drain
    import fmap_out_drain_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = DEF_DATA_IN_WIDTH,
    parameter int DATA_OUT_WIDTH = DEF_DATA_OUT_WIDTH,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int FRAME_WORDS    = DEF_FRAME_WORDS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_en,
    input  logic [DATA_IN_WIDTH-1:0]  data_in,
    output logic                      fifo_afull,
    output logic [DATA_OUT_WIDTH-1:0] data_out,
    output logic                      out_en,
    input  logic                      out_rdy,
    output logic                      done,
    output logic                      overflow
);

    localparam int BEATS  = DATA_IN_WIDTH / DATA_OUT_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WORD_W = $clog2(FRAME_WORDS + 1);

    drainState_e               state_q;
    drainState_e               state_d;
    logic                      frameStart;
    logic                      frameEnd;

    logic                      fifoPush;
    logic                      fifoPop;
    logic                      fifoFull;
    logic                      fifoEmpty;
    logic [OCC_W-1:0]          fifoCount;
    logic [DATA_IN_WIDTH-1:0]  fifoHead;

    logic [DATA_IN_WIDTH-1:0]  word_q;
    logic                      serValid_q;
    logic [BEAT_W-1:0]         beatCnt_q;
    logic [WORD_W-1:0]         accCnt_q;
    logic [WORD_W-1:0]         delCnt_q;
    logic                      overflow_q;

    logic                      xfer;
    logic                      lastBeat;
    logic                      inWindow;
    logic                      dropWord;

    assign xfer     = serValid_q && out_rdy;
    assign lastBeat = xfer && (beatCnt_q == BEAT_W'(BEATS - 1));
    assign fifoPop  = !fifoEmpty && (!serValid_q || lastBeat);
    assign inWindow = (state_q == RUN) && in_en && (accCnt_q < WORD_W'(FRAME_WORDS));
    assign fifoPush = inWindow && (!fifoFull || fifoPop);
    assign dropWord = inWindow && fifoFull && !fifoPop;
    assign frameEnd = (state_q == RUN) && lastBeat && (delCnt_q == WORD_W'(FRAME_WORDS - 1));

    assign out_en     = serValid_q;
    assign data_out   = serValid_q ? word_q[DATA_OUT_WIDTH-1:0] : '0;
    assign done       = (state_q == DONE);
    assign overflow   = overflow_q;
    assign fifo_afull = (fifoCount >= OCC_W'(FIFO_DEPTH - 1));

    drain_fifo #(
        .WIDTH (DATA_IN_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (OCC_W)
    ) uFifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .wdata_i (data_in),
        .rdata_o (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    // Frame state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured while idle.
    always_comb begin
        state_d    = state_q;
        frameStart = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    frameStart = 1'b1;
                end
            end
            RUN: begin
                if (frameEnd) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame bookkeeping: accepted and delivered word counts plus the sticky drop flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            accCnt_q   <= '0;
            delCnt_q   <= '0;
            overflow_q <= 1'b0;
        end else if (frameStart) begin
            accCnt_q   <= '0;
            delCnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (fifoPush) begin
                accCnt_q <= accCnt_q + 1'b1;
            end
            if ((state_q == RUN) && lastBeat) begin
                delCnt_q <= delCnt_q + 1'b1;
            end
            if (dropWord) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Serializer: load from the buffer head, then shift one beat out per transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q     <= '0;
            serValid_q <= 1'b0;
            beatCnt_q  <= '0;
        end else if (fifoPop) begin
            word_q     <= fifoHead;
            serValid_q <= 1'b1;
            beatCnt_q  <= '0;
        end else if (xfer) begin
            word_q    <= word_q >> DATA_OUT_WIDTH;
            beatCnt_q <= lastBeat ? '0 : beatCnt_q + 1'b1;
            if (lastBeat) begin
                serValid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fmap_out_drain.sv
// Scoreboard bench for fmap_out_drain: a queue-based model predicts which
// words are accepted, queues their beats, and a negedge monitor compares
// every DUT output against the model.
module tb_fmap_out_drain;

    localparam int DIN   = 512;
    localparam int DOUT  = 64;
    localparam int DEPTH = 4;
    localparam int FRAME = 16;
    localparam int BEATS = DIN / DOUT;

    logic            clk     = 1'b0;
    logic            rst     = 1'b1;
    logic            start   = 1'b0;
    logic            in_en   = 1'b0;
    logic [DIN-1:0]  data_in = '0;
    logic            out_rdy = 1'b0;
    logic            fifo_afull;
    logic [DOUT-1:0] data_out;
    logic            out_en;
    logic            done;
    logic            overflow;

    int nChecks = 0;
    int nFails  = 0;

    // reference model state
    logic [DOUT-1:0] sb[$];
    logic [DIN-1:0]  bufQ[$];
    bit              mRun = 0, mDone = 0, mSer = 0, mOvf = 0;
    int              mBeatsLeft = 0, mAcc = 0, mDel = 0;

    // monitor statistics
    int              cyc = 0, beatsSeen = 0, outEnCycles = 0, doneCount = 0;
    int              lastXferCyc = 0, doneCyc = 0;
    int              beatCyc[4096];
    logic [DOUT-1:0] beatVal[4096];

    always #5 clk = ~clk;

    fmap_out_drain #(
        .DATA_IN_WIDTH  (DIN),
        .DATA_OUT_WIDTH (DOUT),
        .FIFO_DEPTH     (DEPTH),
        .FRAME_WORDS    (FRAME)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_en      (in_en),
        .data_in    (data_in),
        .fifo_afull (fifo_afull),
        .data_out   (data_out),
        .out_en     (out_en),
        .out_rdy    (out_rdy),
        .done       (done),
        .overflow   (overflow)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // drive one cycle of inputs, sampled by the next rising edge
    task automatic applyStimulus(input bit st, input bit en, input bit rdy, input logic [DIN-1:0] d);
        start   = st;
        in_en   = en;
        out_rdy = rdy;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DIN-1:0] randWord();
        logic [DIN-1:0] w;
        for (int i = 0; i < DIN / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic doReset();
        start = 0; in_en = 0; out_rdy = 0; data_in = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic waitDone(input int d0, input int bound, input string name);
        int n = 0;
        while (doneCount == d0 && n < bound) begin
            applyStimulus(0, 0, 1, '0);
            n++;
        end
        checkOutput(name, 64'(doneCount > d0), 64'd1);
    endtask

    task automatic runFrame(input int spacing);
        applyStimulus(1, 0, 1, '0);
        for (int w = 0; w < FRAME; w++) begin
            applyStimulus(0, 1, 1, randWord());
            repeat (spacing - 1) applyStimulus(0, 0, 1, '0);
        end
    endtask

    // behavioural model, advanced on every rising edge from the bench's own inputs
    task automatic modelStep();
        bit xfer, last, canPop, full, inWin, acc, drp, endNow, wasIdle;
        logic [DIN-1:0] head;
        xfer    = mSer && out_rdy;
        last    = xfer && (mBeatsLeft == 1);
        canPop  = (bufQ.size() > 0) && (!mSer || last);
        full    = (bufQ.size() == DEPTH);
        inWin   = mRun && in_en && (mAcc < FRAME);
        acc     = inWin && (!full || canPop);
        drp     = inWin && full && !canPop;
        endNow  = mRun && last && (mDel == FRAME - 1);
        wasIdle = !mRun && !mDone;
        if (xfer) mBeatsLeft--;
        if (last) begin
            mSer = 0;
            if (mRun) mDel++;
        end
        if (canPop) begin
            head       = bufQ.pop_front();
            mSer       = (head === head) || 1'b1;
            mBeatsLeft = BEATS;
        end
        if (acc) begin
            bufQ.push_back(data_in);
            mAcc++;
            for (int i = 0; i < BEATS; i++) sb.push_back(data_in[i*DOUT +: DOUT]);
        end
        if (drp) mOvf = 1;
        if (mDone) mDone = 0;
        if (wasIdle && start) begin
            mRun = 1; mAcc = 0; mDel = 0; mOvf = 0;
        end
        if (endNow) begin
            mRun = 0; mDone = 1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mRun = 0; mDone = 0; mSer = 0; mOvf = 0;
                mBeatsLeft = 0; mAcc = 0; mDel = 0;
                sb.delete();
                bufQ.delete();
            end else begin
                modelStep();
            end
        end
    end

    // monitor: compare outputs mid-cycle and retire beats on each transfer
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            checkOutput("out_en", 64'(out_en), 64'(mSer));
            checkOutput("done", 64'(done), 64'(mDone));
            checkOutput("overflow", 64'(overflow), 64'(mOvf));
            checkOutput("fifo_afull", 64'(fifo_afull), 64'(bufQ.size() >= DEPTH - 1));
            if (out_en) begin
                outEnCycles++;
                if (sb.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected_beat: got %0h, expected no beat", data_out);
                end else begin
                    checkOutput("data_out", data_out, sb[0]);
                    if (out_rdy) begin
                        beatVal[beatsSeen % 4096] = data_out;
                        beatCyc[beatsSeen % 4096] = cyc;
                        void'(sb.pop_front());
                        beatsSeen++;
                        lastXferCyc = cyc;
                    end
                end
            end else begin
                checkOutput("data_out_idle", data_out, 64'd0);
            end
            if (done) begin
                doneCount++;
                doneCyc = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base, d0, d1, oe0, n;
        logic [DIN-1:0] w;

        // reset state
        #1 rst = 1'b0;
        #2;
        checkOutput("rst_out_en", 64'(out_en), 64'd0);
        checkOutput("rst_data_out", data_out, 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);
        checkOutput("rst_afull", 64'(fifo_afull), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // input while idle is ignored
        base = beatsSeen;
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, randWord());
        repeat (10) applyStimulus(0, 0, 1, '0);
        checkOutput("idle_no_beats", 64'(beatsSeen - base), 64'd0);

        // single word, byte i = i
        doReset();
        oe0  = outEnCycles;
        base = beatsSeen;
        for (int i = 0; i < DIN / 8; i++) w[i*8 +: 8] = 8'(i);
        applyStimulus(1, 0, 1, '0);
        applyStimulus(0, 1, 1, w);
        repeat (20) applyStimulus(0, 0, 1, '0);
        checkOutput("single_out_en_cycles", 64'(outEnCycles - oe0), 64'd8);
        checkOutput("single_beat0", beatVal[base % 4096], 64'h0706050403020100);
        checkOutput("single_beat7", beatVal[(base + 7) % 4096], 64'h3f3e3d3c3b3a3938);

        // full frame, one word every 8 cycles
        doReset();
        base = beatsSeen;
        d0   = doneCount;
        runFrame(8);
        waitDone(d0, 200, "frame_done_seen");
        repeat (3) applyStimulus(0, 0, 1, '0);
        checkOutput("frame_beats", 64'(beatsSeen - base), 64'd128);
        checkOutput("frame_no_gaps", 64'(beatCyc[(base + 127) % 4096] - beatCyc[base % 4096]), 64'd127);
        checkOutput("frame_done_after_last", 64'(doneCyc - lastXferCyc), 64'd1);
        checkOutput("frame_done_once", 64'(doneCount - d0), 64'd1);
        checkOutput("frame_overflow", 64'(overflow), 64'd0);

        // back-pressure mid-word with a dropped word
        doReset();
        base = beatsSeen;
        d0   = doneCount;
        applyStimulus(1, 0, 1, '0);
        applyStimulus(0, 1, 1, randWord());
        repeat (4) applyStimulus(0, 0, 1, '0);
        for (int i = 0; i < 20; i++) applyStimulus(0, (i % 2 == 0) && (i < 10), 0, randWord());
        checkOutput("bp_overflow_set", 64'(overflow), 64'd1);
        checkOutput("bp_afull", 64'(fifo_afull), 64'd1);
        repeat (20) applyStimulus(0, 0, 1, '0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 1, randWord());
            repeat (9) applyStimulus(0, 0, 1, '0);
        end
        repeat (100) applyStimulus(0, 0, 1, '0);
        checkOutput("bp_words_delivered", 64'(beatsSeen - base), 64'd120);
        checkOutput("bp_no_done", 64'(doneCount - d0), 64'd0);
        checkOutput("bp_overflow_sticky", 64'(overflow), 64'd1);

        // push into a full buffer in the same cycle as the last beat
        doReset();
        base = beatsSeen;
        applyStimulus(1, 0, 0, '0);
        applyStimulus(0, 1, 0, randWord());
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, randWord());
        checkOutput("pp_afull", 64'(fifo_afull), 64'd1);
        n = 0;
        while (!(mSer && mBeatsLeft == 1) && n < 20) begin
            applyStimulus(0, 0, 1, '0);
            n++;
        end
        checkOutput("pp_reach_last_beat", 64'(n < 20), 64'd1);
        applyStimulus(0, 1, 1, randWord());
        checkOutput("pp_overflow_clear", 64'(overflow), 64'd0);
        repeat (60) applyStimulus(0, 0, 1, '0);
        checkOutput("pp_words_delivered", 64'(beatsSeen - base), 64'd48);

        // excess input: 18 words offered, 16 delivered
        doReset();
        base = beatsSeen;
        d0   = doneCount;
        applyStimulus(1, 0, 1, '0);
        for (int i = 0; i < 18; i++) begin
            applyStimulus(0, 1, 1, randWord());
            repeat (8) applyStimulus(0, 0, 1, '0);
        end
        repeat (20) applyStimulus(0, 0, 1, '0);
        checkOutput("excess_beats", 64'(beatsSeen - base), 64'd128);
        checkOutput("excess_done_once", 64'(doneCount - d0), 64'd1);
        checkOutput("excess_overflow", 64'(overflow), 64'd0);

        // reset in the middle of a frame
        doReset();
        base = beatsSeen;
        d0   = doneCount;
        applyStimulus(1, 0, 1, '0);
        n = 0;
        while ((beatsSeen - base) < 50 && n < 1000) begin
            applyStimulus(0, (n % 8) == 0, 1, randWord());
            n++;
        end
        checkOutput("mid_reached_50", 64'(n < 1000), 64'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("mid_rst_out_en", 64'(out_en), 64'd0);
        checkOutput("mid_rst_data_out", data_out, 64'd0);
        checkOutput("mid_rst_done", 64'(done), 64'd0);
        checkOutput("mid_rst_overflow", 64'(overflow), 64'd0);
        checkOutput("mid_rst_afull", 64'(fifo_afull), 64'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(0, 0, 1, '0);
        checkOutput("mid_no_done", 64'(doneCount - d0), 64'd0);
        d1   = doneCount;
        base = beatsSeen;
        runFrame(8);
        waitDone(d1, 200, "mid_new_frame_done");
        repeat (3) applyStimulus(0, 0, 1, '0);
        checkOutput("mid_new_frame_beats", 64'(beatsSeen - base), 64'd128);

        // randomized frames with random stalls and drops
        for (int f = 0; f < 2; f++) begin
            base = beatsSeen;
            d0   = doneCount;
            applyStimulus(1, 0, 1, '0);
            n = 0;
            while (doneCount == d0 && n < 3000) begin
                applyStimulus(0, ($urandom % 3) == 0, ($urandom % 4) != 0, randWord());
                n++;
            end
            checkOutput("rand_frame_done", 64'(doneCount > d0), 64'd1);
            repeat (3) applyStimulus(0, 0, 1, '0);
            checkOutput("rand_frame_beats", 64'(beatsSeen - base), 64'd128);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/fmap_out_drain.md
FMAP_OUT_DRAIN -- requirements
Module: fmap_out_drain

Interface
REQ-001 SHALL have parameter DATA_IN_WIDTH, default 512, meaning width of the layer output word.
REQ-002 SHALL have parameter DATA_OUT_WIDTH, default 64, meaning width of one host beat; DATA_IN_WIDTH SHALL be an integer multiple of it (BEATS = DATA_IN_WIDTH/DATA_OUT_WIDTH, 8 at defaults).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the word buffer depth (power of two, >= 2).
REQ-004 SHALL have parameter FRAME_WORDS, default 16, meaning the number of input words per frame.
REQ-005 clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle pulse that begins a frame.
REQ-008 in_en  input  1  data_in valid (layer out_en); there is no back-pressure toward the layer.
REQ-009 data_in  input  DATA_IN_WIDTH  layer output word.
REQ-010 fifo_afull  output  1  buffer occupancy >= FIFO_DEPTH-1; this is advisory to the producer.
REQ-011 data_out  output  DATA_OUT_WIDTH  current beat.
REQ-012 out_en  output  1  data_out valid.
REQ-013 out_rdy  input  1  sink accepts the beat; a transfer occurs when out_en and out_rdy are both high.
REQ-014 done  output  1  one-cycle pulse marking the end of the frame.
REQ-015 overflow  output  1  sticky flag set when an input word is dropped.

Function
REQ-016 SHALL use an FSM with three states:
- IDLE -> RUN on start.
- RUN -> DONE when the last beat of word FRAME_WORDS-1 transfers.
- DONE -> IDLE unconditionally after 1 cycle.
REQ-017 SHALL drive done high only while in DONE.
REQ-018 SHALL ignore start in RUN and DONE.
REQ-019 SHALL, in IDLE and DONE, ignore in_en: nothing stored, nothing counted, overflow unchanged.
REQ-020 SHALL, in RUN, write data_in into the FIFO when in_en is high, the accepted-word count is < FRAME_WORDS, and the FIFO is not full.
REQ-021 SHALL accept the write if the FIFO is full but a pop occurs in the same cycle.
REQ-022 SHALL, when in_en is high in RUN with a full FIFO and no same-cycle pop, drop the word, not count it, and set overflow.
REQ-023 SHALL silently ignore in_en after FRAME_WORDS words have been accepted; this does not set overflow.
REQ-024 SHALL clear overflow only on start (when accepted in IDLE) or on reset.
REQ-025 SHALL load a word from FIFO head into the serializer (pop) when the serializer is empty, or when beat BEATS-1 transfers, and the FIFO is non-empty; back-to-back words SHALL have no bubble cycle.
REQ-026 SHALL give one-cycle latency: a word written at edge k with an empty FIFO and empty serializer is loaded at edge k+1, and out_en is high after edge k+1.
REQ-027 SHALL emit beats LSB-first: beat i = data_in[i*DATA_OUT_WIDTH +: DATA_OUT_WIDTH], with i from 0 to BEATS-1.
REQ-028 SHALL hold data_out and out_en stable while out_en=1 and out_rdy=0.
REQ-029 SHALL deassert out_en when the serializer is empty; data_out is then don't-care, and 0 is driven.
REQ-030 SHALL update the beat counter only on a transfer, wrapping from BEATS-1 to 0.
REQ-031 SHALL compute fifo_afull combinationally from registered occupancy.
REQ-032 SHALL count with widths clog2(FIFO_DEPTH+1) for occupancy, clog2(BEATS) for beats, and clog2(FRAME_WORDS+1) for words.

Reset
REQ-033 SHALL, on rst low, asynchronously force: state=IDLE, FIFO empty (contents discarded), serializer empty, all counters 0, out_en=0, data_out=0, done=0, overflow=0, fifo_afull=0.
REQ-034 SHALL, when rst is asserted mid-frame, abort the frame with no done pulse; after release, the block waits in IDLE for start.

Structure
REQ-035 SHALL place the default parameter values and the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) in the shared include header.
REQ-036 SHALL implement the buffer as one sub-module, drain_fifo: a synchronous single-clock FIFO with push, pop, full, empty and count outputs.
REQ-037 SHALL keep the serializer and FSM in fmap_out_drain.

Verification
REQ-038 Single word: start, one word 0x...0706050403020100 (byte i = i) with out_rdy=1 -> out_en high from the next cycle for exactly 8 cycles; beat0=0x0706050403020100.
REQ-039 Full frame: 16 words, in_en every 8th cycle, out_rdy=1 -> 128 beats in order, no gaps after the first, done pulses 1 cycle after beat 127, overflow=0.
REQ-040 Back-pressure: out_rdy=0 for 20 cycles mid-word -> data_out frozen; fifo_afull rises at occupancy 3; the 5th buffered word while full is dropped and overflow=1; resuming gives 15 delivered words and no done.
REQ-041 Simultaneous push/pop at full: FIFO full, last beat transfers in the same cycle as in_en -> word accepted, overflow stays 0.
REQ-042 IDLE and excess input: in_en before start -> no out_en; 18 words in RUN with FIFO never full -> exactly 16 words delivered, overflow=0.
REQ-043 Reset mid-frame: rst low after 50 beats -> all outputs 0 immediately; no done; new start followed by 16 words -> normal 128-beat frame.
